// File: rtl/cvxif_dispatch_pkg.sv
// Shared types and width helpers for the CVXIF coprocessor dispatcher.
package cvxif_dispatch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Index width for n coprocessors, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  // Width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return int'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/cvxif_dispatch_rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the stored pointer.
module cvxif_dispatch_rr_arb
  import cvxif_dispatch_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] gnt_c
);

  localparam int unsigned IdxW = idx_width(N);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_c = '0;
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    if (found) gnt_c[sel] = 1'b1;
  end

  // Pointer moves just past the granted requester once its grant is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (update && found) begin
      ptr_q <= IdxW'((32'(sel) + 1) % N);
    end
  end

endmodule

// File: rtl/cvxif_coproc_dispatch.sv
// CVXIF issue/result dispatcher between one core port and NrCoproc coprocessors.
// Define CVXIF_DISPATCH_INORDER_EN to return results strictly in issue order.
module cvxif_coproc_dispatch
  import cvxif_dispatch_pkg::*;
#(
  parameter int unsigned NrCoproc    = 2,
  parameter int unsigned Depth       = 4,
  parameter int unsigned IdWidth     = 3,
  parameter int unsigned InstrWidth  = 32,
  parameter int unsigned ResultWidth = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [InstrWidth-1:0]           issue_instr_i,
  input  logic [IdWidth-1:0]              issue_id_i,
  output logic                            issue_accept_o,
  output logic [NrCoproc-1:0]             cp_issue_valid_o,
  output logic [InstrWidth-1:0]           cp_issue_instr_o,
  output logic [IdWidth-1:0]              cp_issue_id_o,
  input  logic [NrCoproc-1:0]             cp_issue_ready_i,
  input  logic [NrCoproc-1:0]             cp_issue_accept_i,
  input  logic [NrCoproc-1:0]             cp_res_valid_i,
  output logic [NrCoproc-1:0]             cp_res_ready_o,
  input  logic [NrCoproc*IdWidth-1:0]     cp_res_id_i,
  input  logic [NrCoproc*ResultWidth-1:0] cp_res_data_i,
  output logic                            res_valid_o,
  input  logic                            res_ready_i,
  output logic [IdWidth-1:0]              res_id_o,
  output logic [ResultWidth-1:0]          res_data_o,
  output logic                            busy_o
);

  localparam int unsigned IdxW = idx_width(NrCoproc);
  localparam int unsigned CntW = cnt_width(Depth);
  localparam int unsigned PtrW = $clog2(Depth);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        count_q;
  logic [IdxW-1:0]        fifo_q [Depth];
  logic [PtrW-1:0]        wptr_q, rptr_q;
  logic [IdxW-1:0]        head;
  logic [IdxW-1:0]        winner;
  logic                   full, run, issue_hs, push, pop, out_free, rr_update;
  logic [NrCoproc-1:0]    res_req, gnt_c, take;
  logic [IdWidth-1:0]     res_id_c;
  logic [ResultWidth-1:0] res_data_c;

  // Issue path: broadcast, zero latency.
  assign full             = (count_q == CntW'(Depth));
  assign run              = (state_q == RUN);
  assign cp_issue_valid_o = {NrCoproc{issue_valid_i & ~full & run}};
  assign cp_issue_instr_o = issue_instr_i;
  assign cp_issue_id_o    = issue_id_i;
  assign issue_ready_o    = (&cp_issue_ready_i) & ~full & run;
  assign issue_hs         = issue_valid_i & issue_ready_o;
  assign issue_accept_o   = issue_hs & (|cp_issue_accept_i);
  assign push             = issue_accept_o;

  always_comb begin
    winner = '0;
    for (int i = int'(NrCoproc) - 1; i >= 0; i--) begin
      if (cp_issue_accept_i[i]) winner = IdxW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= winner;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  assign head = fifo_q[rptr_q];

`ifdef CVXIF_DISPATCH_INORDER_EN
  assign res_req   = cp_res_valid_i & (NrCoproc'(1) << head);
  assign rr_update = 1'b0;
`else
  logic unused_head;
  assign res_req     = cp_res_valid_i;
  assign rr_update   = pop;
  assign unused_head = ^head;
`endif

  cvxif_dispatch_rr_arb #(
    .N(NrCoproc)
  ) u_rr_arb (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    (res_req),
    .update (rr_update),
    .gnt_c  (gnt_c)
  );

  // A result is only taken while something is outstanding and the output slot frees.
  assign out_free       = ~res_valid_o | res_ready_i;
  assign take           = gnt_c & {NrCoproc{out_free & (count_q != '0)}};
  assign cp_res_ready_o = take;
  assign pop            = |take;

  always_comb begin
    res_id_c   = '0;
    res_data_c = '0;
    for (int unsigned i = 0; i < NrCoproc; i++) begin
      if (take[i]) begin
        res_id_c   = cp_res_id_i[i*IdWidth +: IdWidth];
        res_data_c = cp_res_data_i[i*ResultWidth +: ResultWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_o <= 1'b0;
      res_id_o    <= '0;
      res_data_o  <= '0;
    end else if (pop) begin
      res_valid_o <= 1'b1;
      res_id_o    <= res_id_c;
      res_data_o  <= res_data_c;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + CntW'(1);
    end else if (pop && !push) begin
      count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Drain ends once nothing is outstanding and the output slot is not stalled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_i) state_d = DRAIN;
      DRAIN:   if ((count_q == '0) && !(res_valid_o && !res_ready_i)) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign busy_o = (count_q != '0) | (state_q == DRAIN);

  res_needs_outstanding : assert property (
    @(posedge clk_i) disable iff (rst_i) (|cp_res_valid_i) |-> (count_q != '0)
  );

endmodule
